spi_adc_resp: RTL and testbench
===============================

Name: spi_adc_resp

Overview:
- Synthesizable SPI responder that is the slave end of the A2D interface link. It plays the role the ADC128S plays for A2D_intf, built from real RTL rather than a behavioural model.
- Receives a 16-bit command frame on MOSI, with the channel in cmd[13:11].
- Returns a 16-bit frame {4'h0, sample} on MISO.
- Pipelined like the ADC: the data returned in a frame belongs to the channel addressed in the previous completed frame.
- Sits in the sensor/emulation subsystem and is driven by the internal sample bus.

Parameters:
- NUM_CH, 8: number of sample channels. Fixed at 8 because the command carries a 3-bit channel field.
- RES_W, 12: sample width in bits. Response frame is {(16-RES_W) zeros, sample}.

Ports:
- clk  in  1  system clock; SPI signals are oversampled on it.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  slave select, active low, asynchronous to clk.
- SCLK  in  1  SPI clock from master. Idles high. Master changes MOSI on fall and samples MISO on rise.
- MOSI  in  1  command data, MSB first.
- MISO  out  1  response data, MSB first.
- smpl_bus  in  NUM_CH*RES_W  flattened samples; channel n occupies [n*RES_W +: RES_W].
- cmd  out  16  last complete command received.
- cmd_vld  out  1  one-clk pulse when a complete 16-bit frame ends.
- chnl  out  3  channel that will be returned in the next frame.
- frm_err  out  1  one-clk pulse when a frame aborts with bit count != 16.

Behaviour:
- Synchronisation:
  - SS_n, SCLK and MOSI each pass through 2 flops, plus a third flop on SS_n and SCLK for edge detection.
  - Sync reset values: SS_n=1, SCLK=1, MOSI=0.
  - Internal edge events occur 3 clk after the pin edge.
  - The block is only correct if SCLK half-period is >= 4 clk. A2D_intf uses 16.
- Reset values: MISO=0, cmd=16'h0000, cmd_vld=0, chnl=3'b000, frm_err=0, state=IDLE, bit_cnt=0, tx_shft=0, rx_shft=0.
- State IDLE:
  - MISO=0.
  - On synced SS_n fall: load tx_shft={4'h0, smpl_bus[chnl*12 +: 12]}, clear bit_cnt and rx_shft, go to SHIFT.
  - The sample is snapshotted at this point; later smpl_bus changes do not affect the frame.
- State SHIFT:
  - MISO=tx_shft[15], registered.
  - On SCLK rise with bit_cnt<16: rx_shft <= {rx_shft[14:0], MOSI_sync}, bit_cnt++.
  - Rises after bit_cnt reaches 16 are ignored.
  - On SCLK fall with 0<bit_cnt<16: tx_shft <= {tx_shft[14:0], 1'b0}.
  - A fall with bit_cnt==0 (front porch) does not shift, so bit 15 is held until the first rise.
  - On synced SS_n rise, go to IDLE:
    - If bit_cnt==16: cmd <= rx_shft, chnl <= rx_shft[13:11], cmd_vld pulses 1 clk.
    - Otherwise: cmd and chnl unchanged, frm_err pulses 1 clk.
- Simultaneous events:
  - SS_n rise and SCLK edge in the same clk: the SS_n rise wins and the edge is dropped.
  - SS_n fall while in SHIFT cannot occur; SS_n must rise first.
- Reset mid-frame: all state returns to reset values immediately (async). Remaining SCLK edges are ignored until the next SS_n fall.
- Bit 15 and bits 10:0 of the command are stored in cmd but have no other effect.

Test Plan:
- Reset, then a 16-bit frame with MOSI=16'h1800 and smpl_bus ch0=12'h0E7 -> MISO shifts 16'h00E7; after SS_n rises, chnl=3, cmd=16'h1800, cmd_vld high for exactly 1 clk.
- Second frame with ch3=12'hA5C, command 16'h0800 -> MISO returns 16'h0A5C; chnl becomes 1.
- Third frame with ch1=12'h005 -> MISO=16'h0005. Change ch1 to 12'hFFF mid-frame -> MISO still 16'h0005 (snapshot check).
- Abort after 9 SCLK rises (SS_n high) -> frm_err pulse; cmd_vld stays 0; chnl unchanged; the next full frame works normally.
- Frame with 18 SCLK rises -> only the first 16 bits are captured; cmd matches the first 16 MOSI bits; no frm_err.
- Assert rst at bit 8 of a frame -> MISO=0, chnl=0, cmd=0 immediately; after release, no cmd_vld until a new SS_n fall and full frame.

Source files
------------

// File: rtl/spi_adc_resp.sv
// SPI slave that answers A2D_intf like an ADC128S: {zeros, sample} on MISO, command captured from MOSI.
// Returned sample is the channel addressed by the previous complete frame; SPI pins are oversampled on clk.
module spi_adc_resp #(
  parameter int NUM_CH = 8,
  parameter int RES_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SS_n,
  input  logic                      SCLK,
  input  logic                      MOSI,
  output logic                      MISO,
  input  logic [NUM_CH*RES_W-1:0]   smpl_bus,
  output logic [15:0]               cmd,
  output logic                      cmd_vld,
  output logic [2:0]                chnl,
  output logic                      frm_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ss_sync, sclk_sync;
  logic [1:0]  mosi_sync;
  logic [1:0]  settle;
  logic        armed;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [15:0] tx_shft, tx_nxt;
  logic [15:0] rx_shft, rx_nxt;
  logic [15:0] cmd_nxt;
  logic [2:0]  chnl_nxt;
  logic        vld_nxt, err_nxt, miso_nxt;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
  logic [RES_W-1:0] smpl_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      mosi_sync <= 2'b00;
      settle    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
      settle    <= {settle[0], 1'b1};
      // Only accept a frame once SS_n has been seen high after reset, so a
      // frame interrupted by reset is not picked up part-way through.
      armed     <= armed | (settle[1] & ss_sync[1]);
    end
  end

  assign ss_fall   = armed & ss_sync[2] & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2] & ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign smpl_sel  = smpl_bus[32'(chnl)*RES_W +: RES_W];

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx_shft;
    rx_nxt      = rx_shft;
    cmd_nxt     = cmd;
    chnl_nxt    = chnl;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          tx_nxt      = {{(16-RES_W){1'b0}}, smpl_sel};
          rx_nxt      = 16'h0000;
          bit_cnt_nxt = 5'd0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // SS_n rise takes priority; a coincident SCLK edge is dropped.
        if (ss_rise) begin
          state_nxt = IDLE;
          if (bit_cnt == 5'd16) begin
            cmd_nxt  = rx_shft;
            chnl_nxt = rx_shft[13:11];
            vld_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (sclk_rise && bit_cnt < 5'd16) begin
          rx_nxt      = {rx_shft[14:0], mosi_s};
          bit_cnt_nxt = bit_cnt + 5'd1;
        end else if (sclk_fall && bit_cnt != 5'd0 && bit_cnt < 5'd16) begin
          tx_nxt = {tx_shft[14:0], 1'b0};
        end
      end
      default: state_nxt = IDLE;
    endcase
    miso_nxt = (state_nxt == SHIFT) ? tx_nxt[15] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      tx_shft <= 16'h0000;
      rx_shft <= 16'h0000;
      cmd     <= 16'h0000;
      chnl    <= 3'b000;
      cmd_vld <= 1'b0;
      frm_err <= 1'b0;
      MISO    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_shft <= tx_nxt;
      rx_shft <= rx_nxt;
      cmd     <= cmd_nxt;
      chnl    <= chnl_nxt;
      cmd_vld <= vld_nxt;
      frm_err <= err_nxt;
      MISO    <= miso_nxt;
    end
  end

endmodule

// File: tb/tb_spi_adc_resp.sv
// Bench for spi_adc_resp: SPI master driving frames, frame-level reference model, per-cycle output monitor.
module tb_spi_adc_resp;

  logic        clk, rst, SS_n, SCLK, MOSI, MISO;
  logic [95:0] smpl_bus;
  logic [15:0] cmd;
  logic        cmd_vld, frm_err;
  logic [2:0]  chnl;

  int n_tests = 0;
  int n_fail  = 0;
  int n_vld   = 0;
  int n_err   = 0;

  logic [15:0] exp_cmd;
  logic [2:0]  exp_chnl;
  bit          win;
  bit          idle_chk;
  bit          prev_vld, prev_err;

  spi_adc_resp #(.NUM_CH(8), .RES_W(12)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .smpl_bus(smpl_bus), .cmd(cmd), .cmd_vld(cmd_vld), .chnl(chnl), .frm_err(frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Outputs are checked against the model on every cycle outside a frame-end window.
  always @(negedge clk) begin
    if (!rst) begin
      if (!win) begin
        chk("cmd_hold", 32'(cmd), 32'(exp_cmd));
        chk("chnl_hold", 32'(chnl), 32'(exp_chnl));
      end
      if (idle_chk) chk("miso_idle", 32'(MISO), 32'd0);
      if (cmd_vld || frm_err) begin
        chk("pulse_in_window", 32'(win), 32'd1);
        chk("pulse_exclusive", 32'(cmd_vld & frm_err), 32'd0);
      end
      if (cmd_vld) begin
        n_vld++;
        chk("vld_width", 32'(prev_vld), 32'd0);
      end
      if (frm_err) begin
        n_err++;
        chk("err_width", 32'(prev_err), 32'd0);
      end
      prev_vld = cmd_vld;
      prev_err = frm_err;
    end else begin
      prev_vld = 1'b0;
      prev_err = 1'b0;
    end
  end

  // One SPI frame: nrise SCLK rises, optional bus change and reset at given rise index.
  task automatic frame(input logic [15:0] word, input int nrise, input int half,
                       input int chg_at, input logic [95:0] chg_bus, input int rst_at,
                       output logic [15:0] got);
    logic [15:0] expw;
    int          vld0, err0, ev, ee;
    bit          did_rst;
    expw    = {4'h0, smpl_bus[32'(exp_chnl)*12 +: 12]};
    got     = 16'h0000;
    did_rst = 1'b0;
    ev      = 0;
    ee      = 0;
    vld0    = n_vld;
    err0    = n_err;
    idle_chk = 1'b0;
    SS_n = 1'b0;
    wait_clk(half);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? word[15-i] : 1'($urandom);
      wait_clk(half);
      SCLK = 1'b1;
      if (!did_rst && i < 16) begin
        got[15-i] = MISO;
        chk("miso_bit", 32'(MISO), 32'(expw[15-i]));
      end
      if (i == chg_at) smpl_bus = chg_bus;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_chnl", 32'(chnl), 32'd0);
        chk("rst_vld", 32'(cmd_vld), 32'd0);
        exp_cmd  = 16'h0000;
        exp_chnl = 3'd0;
        did_rst  = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
      wait_clk(half);
    end
    SS_n = 1'b1;
    win  = 1'b1;
    if (!did_rst) begin
      if (nrise >= 16) begin
        exp_cmd  = word;
        exp_chnl = word[13:11];
        ev = 1;
      end else begin
        ee = 1;
      end
    end
    wait_clk(6);
    win = 1'b0;
    idle_chk = 1'b1;
    chk("vld_count", 32'(n_vld - vld0), 32'(ev));
    chk("err_count", 32'(n_err - err0), 32'(ee));
    wait_clk(4);
  endtask

  initial begin
    logic [15:0] got;
    logic [95:0] bus;
    logic [15:0] w;
    int nr;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    win = 1'b1; idle_chk = 1'b0;
    exp_cmd = 16'h0000; exp_chnl = 3'd0;
    smpl_bus = {$urandom, $urandom, $urandom};
    smpl_bus[0*12 +: 12] = 12'h0E7;
    smpl_bus[3*12 +: 12] = 12'hA5C;
    smpl_bus[1*12 +: 12] = 12'h005;
    wait_clk(3);
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_cmd", 32'(cmd), 32'd0);
    chk("reset_vld", 32'(cmd_vld), 32'd0);
    chk("reset_chnl", 32'(chnl), 32'd0);
    chk("reset_err", 32'(frm_err), 32'd0);
    rst = 1'b0;
    wait_clk(6);
    win = 1'b0;
    idle_chk = 1'b1;

    frame(16'h1800, 16, 16, -1, '0, -1, got);
    chk("f1_miso_word", 32'(got), 32'h00E7);
    chk("f1_cmd", 32'(cmd), 32'h1800);
    chk("f1_chnl", 32'(chnl), 32'd3);

    frame(16'h0800, 16, 16, -1, '0, -1, got);
    chk("f2_miso_word", 32'(got), 32'h0A5C);
    chk("f2_chnl", 32'(chnl), 32'd1);

    bus = smpl_bus;
    bus[1*12 +: 12] = 12'hFFF;
    frame(16'h3000, 16, 8, 7, bus, -1, got);
    chk("f3_snapshot_word", 32'(got), 32'h0005);
    chk("f3_chnl", 32'(chnl), 32'd6);

    frame(16'h1000, 9, 8, -1, '0, -1, got);
    chk("abort_chnl", 32'(chnl), 32'd6);
    chk("abort_cmd", 32'(cmd), 32'h3000);

    frame(16'h2000, 16, 6, -1, '0, -1, got);
    chk("after_abort_word", 32'(got), 32'(smpl_bus[6*12 +: 12]));
    chk("after_abort_chnl", 32'(chnl), 32'd4);

    frame(16'h5A5A, 18, 6, -1, '0, -1, got);
    chk("long_cmd", 32'(cmd), 32'h5A5A);
    chk("long_chnl", 32'(chnl), 32'd3);

    frame(16'h3800, 16, 8, -1, '0, 8, got);
    chk("post_rst_cmd", 32'(cmd), 32'd0);
    chk("post_rst_chnl", 32'(chnl), 32'd0);

    frame(16'h2800, 16, 8, -1, '0, -1, got);
    chk("post_rst_word", 32'(got), 32'(smpl_bus[11:0]));
    chk("post_rst_new_chnl", 32'(chnl), 32'd5);

    for (int k = 0; k < 40; k++) begin
      w   = 16'($urandom);
      bus = {$urandom, $urandom, $urandom};
      nr  = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(1, 18));
      frame(w, nr, int'($urandom_range(4, 12)), int'($urandom_range(0, 15)), bus, -1, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
